serial_word_shifter: RTL and testbench

Upstream feeder for the team's serial Mealy sequence detectors. It accepts parallel words over a valid/ready handshake and holds one of them in a one-deep buffer. It shifts each word out one bit per clock on x_out, which drives the detector's x input. Between words it inserts a programmable gap at a fixed idle level so the downstream detector sees clean frame boundaries.

---
 rtl/ser_pkg.sv | 22 ++
 rtl/ser_gap_timer.sv | 37 +++
 rtl/serial_word_shifter.sv | 193 +++++++++++++++++++
 tb/tb_serial_word_shifter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ser_pkg.sv
// Shared types and constants for the serial word shifter.
// Contents: state encoding, default word width / gap length, even-parity helper.
package ser_pkg;

  localparam int unsigned SER_WIDTH_DEF = 8;
  localparam int unsigned SER_GAP_DEF   = 2;
  // Widest word the parity helper handles; callers zero-extend into it.
  localparam int unsigned SER_PAR_MAX_W = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    GAP    = 2'd2,
    PARITY = 2'd3
  } ser_state_t;

  // Even parity; zero-extension does not change the result.
  function automatic logic ser_parity(input logic [SER_PAR_MAX_W-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/ser_gap_timer.sv
// Loadable down-counter that times the idle gap between words.
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous active-low reset
//   i_start   load the counter; the gap begins in the following cycle
//   o_expired registered: current cycle is the last gap cycle (or timer idle)
module ser_gap_timer #(
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_start,
  output logic o_expired
);

  localparam int unsigned CNT_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  logic [CNT_W-1:0] r_cnt;
  logic             r_expired;

  // Count holds remaining gap cycles after the current one; expired tracks cnt == 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt     <= '0;
      r_expired <= 1'b1;
    end else if (i_start) begin
      r_cnt     <= CNT_W'(GAP_CYCLES - 1);
      r_expired <= (GAP_CYCLES <= 1);
    end else if (r_cnt != '0) begin
      r_cnt     <= r_cnt - CNT_W'(1);
      r_expired <= (r_cnt == CNT_W'(1));
    end
  end

  assign o_expired = r_expired;

endmodule

// File: rtl/serial_word_shifter.sv
// Parallel-to-serial feeder for the serial sequence detectors: one-deep word
// buffer behind a valid/ready handshake, bit-serial output with an idle gap
// of GAP_CYCLES between words.
// Optional feature: define SER_PARITY_EN to append an even-parity bit per word.
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   in_data    parallel word (WIDTH bits)
//   in_valid   in_data valid
//   in_ready   buffer empty, a word is accepted this cycle if in_valid
//   x_out      serial bit stream (IDLE_LEVEL when no bit is valid)
//   x_valid    x_out carries a data or parity bit
//   busy       FSM not idle or buffer occupied
//   word_done  pulse with the last bit of a word
module serial_word_shifter
  import ser_pkg::*;
#(
  parameter int unsigned WIDTH      = SER_WIDTH_DEF,
  parameter int unsigned GAP_CYCLES = SER_GAP_DEF,
  parameter logic        IDLE_LEVEL = 1'b0,
  parameter logic        MSB_FIRST  = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             x_out,
  output logic             x_valid,
  output logic             busy,
  output logic             word_done
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  ser_state_t       r_state,     w_state_nxt;
  logic [WIDTH-1:0] r_buf,       w_buf_nxt;
  logic             r_buf_full,  w_buf_full_nxt;
  logic             r_in_ready;
  logic [WIDTH-1:0] r_shreg,     w_shreg_nxt;
  logic [CNT_W-1:0] r_bit_cnt,   w_bit_cnt_nxt;
  logic             r_x_out,     w_x_out_nxt;
  logic             r_x_valid,   w_x_valid_nxt;
  logic             r_word_done, w_word_done_nxt;
  logic             r_busy,      w_busy_nxt;
  logic             w_load;
  logic             w_end_word;
  logic             w_gap_start;
  logic             w_gap_expired;
`ifdef SER_PARITY_EN
  logic             r_parity,    w_parity_nxt;
`endif

  ser_gap_timer #(
    .GAP_CYCLES (GAP_CYCLES)
  ) u_gap_timer (
    .clk       (clk),
    .reset     (reset),
    .i_start   (w_gap_start),
    .o_expired (w_gap_expired)
  );

  // Next-state and next-output logic; every register's D input is computed here.
  always_comb begin
    w_state_nxt     = r_state;
    w_buf_nxt       = r_buf;
    w_buf_full_nxt  = r_buf_full;
    w_shreg_nxt     = r_shreg;
    w_bit_cnt_nxt   = r_bit_cnt;
    w_x_out_nxt     = IDLE_LEVEL;
    w_x_valid_nxt   = 1'b0;
    w_word_done_nxt = 1'b0;
    w_load          = 1'b0;
    w_end_word      = 1'b0;
    w_gap_start     = 1'b0;
`ifdef SER_PARITY_EN
    w_parity_nxt    = r_parity;
`endif

    unique case (r_state)
      IDLE: begin
        w_load = r_buf_full;
      end
      SHIFT: begin
        // r_bit_cnt = bits still to show after the one currently on x_out
        if (r_bit_cnt != '0) begin
          w_bit_cnt_nxt = r_bit_cnt - CNT_W'(1);
          w_x_out_nxt   = MSB_FIRST ? r_shreg[WIDTH-1] : r_shreg[0];
          w_shreg_nxt   = MSB_FIRST ? (r_shreg << 1) : (r_shreg >> 1);
          w_x_valid_nxt = 1'b1;
`ifndef SER_PARITY_EN
          w_word_done_nxt = (r_bit_cnt == CNT_W'(1));
`endif
        end else begin
`ifdef SER_PARITY_EN
          w_state_nxt     = PARITY;
          w_x_out_nxt     = r_parity;
          w_x_valid_nxt   = 1'b1;
          w_word_done_nxt = 1'b1;
`else
          w_end_word      = 1'b1;
`endif
        end
      end
      GAP: begin
        if (w_gap_expired) begin
          w_load = r_buf_full;
          if (!r_buf_full) w_state_nxt = IDLE;
        end
      end
      PARITY: begin
`ifdef SER_PARITY_EN
        w_end_word = 1'b1;
`else
        w_state_nxt = IDLE;
`endif
      end
    endcase

    // Word finished: open the gap, or chain straight into the next word.
    if (w_end_word) begin
      if (GAP_CYCLES != 0) begin
        w_state_nxt = GAP;
        w_gap_start = 1'b1;
      end else if (r_buf_full) begin
        w_load = 1'b1;
      end else begin
        w_state_nxt = IDLE;
      end
    end

    // Buffer -> shift register, first bit presented at the same edge.
    if (w_load) begin
      w_state_nxt    = SHIFT;
      w_buf_full_nxt = 1'b0;
      w_x_out_nxt    = MSB_FIRST ? r_buf[WIDTH-1] : r_buf[0];
      w_shreg_nxt    = MSB_FIRST ? (r_buf << 1) : (r_buf >> 1);
      w_bit_cnt_nxt  = CNT_W'(WIDTH - 1);
      w_x_valid_nxt  = 1'b1;
`ifdef SER_PARITY_EN
      w_parity_nxt   = ser_parity(SER_PAR_MAX_W'(r_buf));
`endif
    end

    // Accept only into an empty buffer, so it never coincides with a load.
    if (in_valid && !r_buf_full) begin
      w_buf_nxt      = in_data;
      w_buf_full_nxt = 1'b1;
    end

    w_busy_nxt = (w_state_nxt != IDLE) || w_buf_full_nxt;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_buf       <= '0;
      r_buf_full  <= 1'b0;
      r_in_ready  <= 1'b1;
      r_shreg     <= '0;
      r_bit_cnt   <= '0;
      r_x_out     <= IDLE_LEVEL;
      r_x_valid   <= 1'b0;
      r_word_done <= 1'b0;
      r_busy      <= 1'b0;
`ifdef SER_PARITY_EN
      r_parity    <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_buf       <= w_buf_nxt;
      r_buf_full  <= w_buf_full_nxt;
      r_in_ready  <= ~w_buf_full_nxt;
      r_shreg     <= w_shreg_nxt;
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_x_out     <= w_x_out_nxt;
      r_x_valid   <= w_x_valid_nxt;
      r_word_done <= w_word_done_nxt;
      r_busy      <= w_busy_nxt;
`ifdef SER_PARITY_EN
      r_parity    <= w_parity_nxt;
`endif
    end
  end

  assign in_ready  = r_in_ready;
  assign x_out     = r_x_out;
  assign x_valid   = r_x_valid;
  assign busy      = r_busy;
  assign word_done = r_word_done;

endmodule

// File: tb/tb_serial_word_shifter.sv
// Testbench for serial_word_shifter. Three instances:
//   lane 0: GAP=2, MSB first, idle 0
//   lane 1: GAP=2, LSB first, idle 1
//   lane 2: GAP=0, MSB first, idle 0
// Honours SER_PARITY_EN for the expected bit stream.
module tb_serial_word_shifter;

  localparam int W = 8;
  localparam int G = 2;
`ifdef SER_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam logic [2:0] IDLE_L = 3'b010;
  localparam logic [2:0] MSB_L  = 3'b101;

  typedef struct packed {
    logic b;
    logic d;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data [3];
  logic [2:0] in_valid;
  logic [2:0] in_ready;
  logic [2:0] x_out;
  logic [2:0] x_valid;
  logic [2:0] busy;
  logic [2:0] word_done;

  exp_t sbq    [3][$];
  int   done_t [3][$];
  int   runs   [3][$];
  int   run    [3];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_word_shifter #(.WIDTH(8), .GAP_CYCLES(2), .IDLE_LEVEL(1'b0), .MSB_FIRST(1'b1)) u_dut0 (
    .clk(clk), .reset(rst_n), .in_data(in_data[0]), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .x_out(x_out[0]), .x_valid(x_valid[0]),
    .busy(busy[0]), .word_done(word_done[0]));

  serial_word_shifter #(.WIDTH(8), .GAP_CYCLES(2), .IDLE_LEVEL(1'b1), .MSB_FIRST(1'b0)) u_dut1 (
    .clk(clk), .reset(rst_n), .in_data(in_data[1]), .in_valid(in_valid[1]),
    .in_ready(in_ready[1]), .x_out(x_out[1]), .x_valid(x_valid[1]),
    .busy(busy[1]), .word_done(word_done[1]));

  serial_word_shifter #(.WIDTH(8), .GAP_CYCLES(0), .IDLE_LEVEL(1'b0), .MSB_FIRST(1'b1)) u_dut2 (
    .clk(clk), .reset(rst_n), .in_data(in_data[2]), .in_valid(in_valid[2]),
    .in_ready(in_ready[2]), .x_out(x_out[2]), .x_valid(x_valid[2]),
    .busy(busy[2]), .word_done(word_done[2]));

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference bit stream for one word.
  function automatic void push_word(input int lane, input logic [7:0] d);
    exp_t e;
    for (int k = 0; k < W; k++) begin
      e.b = MSB_L[lane] ? d[W-1-k] : d[k];
      e.d = (k == W-1) && (PAR == 0);
      sbq[lane].push_back(e);
    end
    if (PAR != 0) begin
      e.b = ^d;
      e.d = 1'b1;
      sbq[lane].push_back(e);
    end
  endfunction

  // Present a word, wait for ready, return after the accepting edge.
  task automatic send(input int lane, input logic [7:0] d, output int waits);
    in_data[lane]  = d;
    in_valid[lane] = 1'b1;
    waits = 0;
    while (!in_ready[lane] && waits < 300) begin
      @(negedge clk);
      waits++;
    end
    chk1("send_ready", in_ready[lane], 1'b1);
    push_word(lane, d);
    @(negedge clk);
    in_valid[lane] = 1'b0;
  endtask

  task automatic drain(input int lane);
    int n;
    n = 0;
    while (sbq[lane].size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chkn($sformatf("drain_lane%0d", lane), sbq[lane].size(), 0);
    repeat (4) @(negedge clk);
  endtask

  // Scoreboard monitor: every valid bit against the model, idle level otherwise.
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) run[i] = 0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (x_valid[i]) begin
          exp_t e;
          run[i]++;
          chkn($sformatf("sb_nonempty_lane%0d", i), int'(sbq[i].size() != 0), 1);
          if (sbq[i].size() != 0) begin
            e = sbq[i].pop_front();
            chk1($sformatf("x_out_lane%0d", i), x_out[i], e.b);
            chk1($sformatf("word_done_lane%0d", i), word_done[i], e.d);
          end
          if (word_done[i]) done_t[i].push_back(cyc);
        end else begin
          chk1($sformatf("idle_level_lane%0d", i), x_out[i], IDLE_L[i]);
          chk1($sformatf("idle_done_lane%0d", i), word_done[i], 1'b0);
          if (run[i] != 0) begin
            runs[i].push_back(run[i]);
            run[i] = 0;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int waits;
    int n;
    rst_n    = 1'b0;
    in_valid = '0;
    for (int i = 0; i < 3; i++) in_data[i] = '0;
    for (int i = 0; i < 3; i++) run[i] = 0;

    // Reset values
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk1($sformatf("rst_x_out_lane%0d", i), x_out[i], IDLE_L[i]);
      chk1($sformatf("rst_x_valid_lane%0d", i), x_valid[i], 1'b0);
      chk1($sformatf("rst_word_done_lane%0d", i), word_done[i], 1'b0);
      chk1($sformatf("rst_busy_lane%0d", i), busy[i], 1'b0);
      chk1($sformatf("rst_in_ready_lane%0d", i), in_ready[i], 1'b1);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // 8'hB4 on MSB-first and LSB-first lanes, with latency checks
    in_data[0] = 8'hB4;
    in_data[1] = 8'hB4;
    in_valid[1:0] = 2'b11;
    push_word(0, 8'hB4);
    push_word(1, 8'hB4);
    @(negedge clk);
    in_valid[1:0] = 2'b00;
    chk1("lat_accept_x_valid", x_valid[0], 1'b0);
    chk1("lat_accept_in_ready", in_ready[0], 1'b0);
    chk1("lat_accept_busy", busy[0], 1'b1);
    @(negedge clk);
    chk1("lat_first_x_valid", x_valid[0], 1'b1);
    chk1("lat_first_bit_msb", x_out[0], 1'b1);
    chk1("lat_first_bit_lsb", x_out[1], 1'b0);
    chk1("lat_transfer_in_ready", in_ready[0], 1'b1);
    drain(0);
    drain(1);
    chk1("post_word_busy", busy[0], 1'b0);

    // Backpressure: three words with in_valid held
    done_t[0].delete();
    send(0, 8'hFF, waits);
    send(0, 8'h0F, waits);
    chk1("bp_ready_low", in_ready[0], 1'b0);
    send(0, 8'h33, waits);
    chkn("bp_wait_cycles", waits, W + PAR + G - 1);
    drain(0);
    chkn("bp_word_count", done_t[0].size(), 3);
    if (done_t[0].size() == 3) begin
      chkn("bp_period_1", done_t[0][1] - done_t[0][0], W + PAR + G);
      chkn("bp_period_2", done_t[0][2] - done_t[0][1], W + PAR + G);
    end

    // GAP_CYCLES = 0: continuous stream
    done_t[2].delete();
    runs[2].delete();
    send(2, 8'hF0, waits);
    send(2, 8'h0F, waits);
    drain(2);
    chkn("b2b_word_count", done_t[2].size(), 2);
    if (done_t[2].size() == 2)
      chkn("b2b_period", done_t[2][1] - done_t[2][0], W + PAR);
    chkn("b2b_run_count", runs[2].size(), 1);
    if (runs[2].size() == 1)
      chkn("b2b_run_length", runs[2][0], 2 * (W + PAR));

    // Reset in the middle of 8'hAA
    send(0, 8'hAA, waits);
    n = 0;
    while (!x_valid[0] && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk1("mid_started", x_valid[0], 1'b1);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk1("mid_rst_x_valid", x_valid[0], 1'b0);
    chk1("mid_rst_x_out", x_out[0], 1'b0);
    chk1("mid_rst_word_done", word_done[0], 1'b0);
    chk1("mid_rst_busy", busy[0], 1'b0);
    chk1("mid_rst_in_ready", in_ready[0], 1'b1);
    for (int i = 0; i < 3; i++) sbq[i].delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk1("post_rst_quiet", x_valid[0], 1'b0);
    end

    // Recovery and extra patterns (parity 0 and 1 words)
    send(0, 8'h5A, waits);
    send(0, 8'h07, waits);
    drain(0);
    send(1, 8'h07, waits);
    drain(1);
    send(2, 8'h07, waits);
    drain(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
